apb_master_arbiter: RTL and testbench

- Arbitrates NUM_REQ internal requesters onto one shared APB master port that drives the bridge's downstream APB slave.
- Sequences IDLE/SETUP/ACCESS phases and applies round-robin fairness.
- Enforces a per-transfer wait-state timeout and returns read data and error status to the requester that was granted.

---
 rtl/apb_master_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
// Round-robin arbiter that shares one APB master port among NUM_REQ internal
// requesters. Sequences the IDLE/SETUP/ACCESS phases, aborts a transfer whose
// slave keeps pready low for too long, and returns read data and error status
// to the requester that owned the bus. Every output is driven from a register.
module apb_master_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*STRB_WIDTH-1:0] req_strobe,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         resp_rdata,
    output logic                          resp_err,
    output logic [ADDR_WIDTH-1:0]         addr,
    output logic                          sel,
    output logic                          enable,
    output logic                          write,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [STRB_WIDTH-1:0]         strobe,
    input  logic                          ready,
    input  logic                          slverr,
    input  logic [DATA_WIDTH-1:0]         rdata
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                 state_r, state_s;
    logic [PTR_W-1:0]       ptr_r, ptr_s;
    logic [PTR_W-1:0]       winner_r, winner_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic [NUM_REQ-1:0]     gnt_r, gnt_s;
    logic [NUM_REQ-1:0]     done_r, done_s;
    logic [DATA_WIDTH-1:0]  resp_rdata_r, resp_rdata_s;
    logic                   resp_err_r, resp_err_s;
    logic [ADDR_WIDTH-1:0]  addr_r, addr_s;
    logic                   sel_r, sel_s;
    logic                   enable_r, enable_s;
    logic                   write_r, write_s;
    logic [DATA_WIDTH-1:0]  wdata_r, wdata_s;
    logic [STRB_WIDTH-1:0]  strobe_r, strobe_s;

    logic [NUM_REQ-1:0]     eligible_s;
    logic [PTR_W-1:0]       pick_s;
    logic [PTR_W-1:0]       ptr_next_s;
    logic                   timeout_hit_s;

    // First eligible requester found by walking upward from ptr with wrap-around.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                                 input logic [PTR_W-1:0]   ptr);
        logic [PTR_W-1:0] pick;
        logic [PTR_W-1:0] idx;
        logic             found;
        pick  = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && elig[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
            if (idx == PTR_MAX) begin
                idx = '0;
            end else begin
                idx = idx + PTR_W'(1);
            end
        end
        return pick;
    endfunction

    // Next-state and next-output computation for the bus sequencer.
    always_comb begin
        state_s      = state_r;
        ptr_s        = ptr_r;
        winner_s     = winner_r;
        cnt_s        = cnt_r;
        gnt_s        = gnt_r;
        done_s       = '0;
        resp_rdata_s = '0;
        resp_err_s   = 1'b0;
        addr_s       = addr_r;
        sel_s        = sel_r;
        enable_s     = enable_r;
        write_s      = write_r;
        wdata_s      = wdata_r;
        strobe_s     = strobe_r;

        // A requester still seeing its done pulse cannot win again this cycle.
        eligible_s    = req & ~done_r;
        pick_s        = rr_pick(eligible_s, ptr_r);
        ptr_next_s    = (winner_r == PTR_MAX) ? '0 : (winner_r + PTR_W'(1));
        timeout_hit_s = (TIMEOUT > 0) && (cnt_r == CNT_LAST);

        case (state_r)
            ST_IDLE: begin
                if (|eligible_s) begin
                    winner_s         = pick_s;
                    gnt_s            = '0;
                    gnt_s[pick_s]    = 1'b1;
                    addr_s           = req_addr[int'(pick_s)*ADDR_WIDTH +: ADDR_WIDTH];
                    write_s          = req_write[pick_s];
                    wdata_s          = req_wdata[int'(pick_s)*DATA_WIDTH +: DATA_WIDTH];
                    strobe_s         = req_strobe[int'(pick_s)*STRB_WIDTH +: STRB_WIDTH];
                    sel_s            = 1'b1;
                    enable_s         = 1'b0;
                    cnt_s            = '0;
                    state_s          = ST_SETUP;
                end else begin
                    gnt_s    = '0;
                    sel_s    = 1'b0;
                    enable_s = 1'b0;
                end
            end
            ST_SETUP: begin
                enable_s = 1'b1;
                state_s  = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (ready || timeout_hit_s) begin
                    state_s  = ST_IDLE;
                    sel_s    = 1'b0;
                    enable_s = 1'b0;
                    gnt_s    = '0;
                    done_s   = gnt_r;
                    ptr_s    = ptr_next_s;
                    if (ready) begin
                        resp_err_s   = slverr;
                        resp_rdata_s = (!write_r && !slverr) ? rdata : '0;
                    end else begin
                        resp_err_s   = 1'b1;
                        resp_rdata_s = '0;
                    end
                end else begin
                    // Wait-state counter saturates rather than wrapping.
                    cnt_s = (cnt_r == '1) ? cnt_r : (cnt_r + CNT_W'(1));
                end
            end
            default: begin
                state_s  = ST_IDLE;
                sel_s    = 1'b0;
                enable_s = 1'b0;
                gnt_s    = '0;
            end
        endcase
    end

    // State and output registers; asynchronous reset returns everything to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            ptr_r        <= '0;
            winner_r     <= '0;
            cnt_r        <= '0;
            gnt_r        <= '0;
            done_r       <= '0;
            resp_rdata_r <= '0;
            resp_err_r   <= 1'b0;
            addr_r       <= '0;
            sel_r        <= 1'b0;
            enable_r     <= 1'b0;
            write_r      <= 1'b0;
            wdata_r      <= '0;
            strobe_r     <= '0;
        end else begin
            state_r      <= state_s;
            ptr_r        <= ptr_s;
            winner_r     <= winner_s;
            cnt_r        <= cnt_s;
            gnt_r        <= gnt_s;
            done_r       <= done_s;
            resp_rdata_r <= resp_rdata_s;
            resp_err_r   <= resp_err_s;
            addr_r       <= addr_s;
            sel_r        <= sel_s;
            enable_r     <= enable_s;
            write_r      <= write_s;
            wdata_r      <= wdata_s;
            strobe_r     <= strobe_s;
        end
    end

    assign gnt        = gnt_r;
    assign done       = done_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign addr       = addr_r;
    assign sel        = sel_r;
    assign enable     = enable_r;
    assign write      = write_r;
    assign wdata      = wdata_r;
    assign strobe     = strobe_r;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Testbench for apb_master_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbiter.
module tb_apb_master_arbiter;

    localparam int NR = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NR-1:0]  req;
    logic [NR*AW-1:0] req_addr;
    logic [NR-1:0]  req_write;
    logic [NR*DW-1:0] req_wdata;
    logic [NR*SW-1:0] req_strobe;
    logic [NR-1:0]  gnt;
    logic [NR-1:0]  done;
    logic [DW-1:0]  resp_rdata;
    logic           resp_err;
    logic [AW-1:0]  addr;
    logic           sel;
    logic           enable;
    logic           write;
    logic [DW-1:0]  wdata;
    logic [SW-1:0]  strobe;
    logic           ready;
    logic           slverr;
    logic [DW-1:0]  rdata;

    int n_vec = 0;
    int n_err = 0;

    apb_master_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_write(req_write),
        .req_wdata(req_wdata), .req_strobe(req_strobe), .gnt(gnt), .done(done),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .addr(addr), .sel(sel),
        .enable(enable), .write(write), .wdata(wdata), .strobe(strobe),
        .ready(ready), .slverr(slverr), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic wr,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        req = req | (NR'(1) << i);
        req_write = wr ? (req_write | (NR'(1) << i)) : (req_write & ~(NR'(1) << i));
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
        req_strobe[i*SW +: SW] = s;
    endtask

    task automatic drop_req(input int i);
        req = req & ~(NR'(1) << i);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strobe = '0;
        ready = 1'b0; slverr = 1'b0; rdata = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_vec++; if ({sel, enable, write, resp_err} !== 4'b0000) begin n_err++;
            $display("FAIL reset_ctrl got sel=%b en=%b wr=%b err=%b exp all 0", sel, enable, write, resp_err); end
        n_vec++; if (gnt !== '0 || done !== '0) begin n_err++;
            $display("FAIL reset_gnt got gnt=%b done=%b exp 0", gnt, done); end
        n_vec++; if (addr !== '0 || wdata !== '0 || strobe !== '0 || resp_rdata !== '0) begin n_err++;
            $display("FAIL reset_data got addr=%h wdata=%h strb=%h rdata=%h exp 0", addr, wdata, strobe, resp_rdata); end
        rst_n = 1'b1;
        tick();
        n_vec++; if (sel !== 1'b0 || gnt !== '0) begin n_err++;
            $display("FAIL reset_idle got sel=%b gnt=%b exp 0", sel, gnt); end
    endtask

    task automatic test_single_write();
        set_req(0, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF);
        ready = 1'b1;
        tick();
        n_vec++; if (sel !== 1'b1 || enable !== 1'b0 || gnt !== NR'(1) || done !== '0) begin n_err++;
            $display("FAIL wr_setup got sel=%b en=%b gnt=%b done=%b exp 1 0 001 000", sel, enable, gnt, done); end
        n_vec++; if (addr !== 32'h10 || write !== 1'b1 || wdata !== 32'hDEAD_BEEF || strobe !== 4'hF) begin n_err++;
            $display("FAIL wr_fields got addr=%h wr=%b wdata=%h strb=%h", addr, write, wdata, strobe); end
        tick();
        n_vec++; if (sel !== 1'b1 || enable !== 1'b1 || gnt !== NR'(1)) begin n_err++;
            $display("FAIL wr_access got sel=%b en=%b gnt=%b exp 1 1 001", sel, enable, gnt); end
        tick();
        n_vec++; if (sel !== 1'b0 || enable !== 1'b0 || gnt !== '0 || done !== NR'(1)) begin n_err++;
            $display("FAIL wr_done got sel=%b en=%b gnt=%b done=%b exp 0 0 000 001", sel, enable, gnt, done); end
        n_vec++; if (resp_err !== 1'b0 || resp_rdata !== '0) begin n_err++;
            $display("FAIL wr_resp got err=%b rdata=%h exp 0 0", resp_err, resp_rdata); end
        drop_req(0);
        tick();
        n_vec++; if (done !== '0 || sel !== 1'b0) begin n_err++;
            $display("FAIL wr_after got done=%b sel=%b exp 0 0", done, sel); end
    endtask

    task automatic test_round_robin();
        int  exp_w;
        bit  got;
        do_reset();
        set_req(0, 32'h100, 1'b1, 32'h1111_0000, 4'hF);
        set_req(1, 32'h200, 1'b1, 32'h2222_0000, 4'hF);
        ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_w = t % 2;
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                tick();
                if (done !== '0) got = 1'b1;
            end
            n_vec++; if (!got || done !== (NR'(1) << exp_w)) begin n_err++;
                $display("FAIL rr_order t=%0d got done=%b exp %b", t, done, NR'(1) << exp_w); end
            n_vec++; if (sel !== 1'b0) begin n_err++;
                $display("FAIL rr_gap t=%0d got sel=%b exp 0", t, sel); end
            drop_req(exp_w);
            if (t == 3) req = '0;
            tick();
            if (t < 3) req = req | (NR'(1) << exp_w);
        end
        repeat (2) tick();
    endtask

    task automatic test_wait_states();
        set_req(1, 32'h2000_0040, 1'b0, 32'h0, 4'h3);
        ready = 1'b0;
        tick();
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_vec++; if (sel !== 1'b1 || enable !== 1'b1 || gnt !== NR'(2) || done !== '0) begin n_err++;
                $display("FAIL ws_access k=%0d got sel=%b en=%b gnt=%b done=%b", k, sel, enable, gnt, done); end
            n_vec++; if (addr !== 32'h2000_0040 || write !== 1'b0 || strobe !== 4'h3) begin n_err++;
                $display("FAIL ws_stable k=%0d got addr=%h wr=%b strb=%h", k, addr, write, strobe); end
            if (k == 4) begin ready = 1'b1; rdata = 32'h0000_1234; end
        end
        tick();
        n_vec++; if (done !== NR'(2) || resp_rdata !== 32'h0000_1234 || resp_err !== 1'b0) begin n_err++;
            $display("FAIL ws_done got done=%b rdata=%h err=%b exp 010 00001234 0", done, resp_rdata, resp_err); end
        drop_req(1); ready = 1'b0; rdata = '0;
        tick();
        n_vec++; if (resp_rdata !== '0 || done !== '0) begin n_err++;
            $display("FAIL ws_clear got rdata=%h done=%b exp 0", resp_rdata, done); end
    endtask

    task automatic test_slave_error();
        set_req(0, 32'h44, 1'b0, 32'h0, 4'h0);
        ready = 1'b1; slverr = 1'b1; rdata = 32'h0000_FFFF;
        repeat (3) tick();
        n_vec++; if (done !== NR'(1) || resp_err !== 1'b1 || resp_rdata !== '0) begin n_err++;
            $display("FAIL serr_done got done=%b err=%b rdata=%h exp 001 1 0", done, resp_err, resp_rdata); end
        drop_req(0); slverr = 1'b0; ready = 1'b0; rdata = '0;
        tick();
    endtask

    task automatic test_timeout();
        int  n_access;
        bit  got;
        n_access = 0;
        got = 1'b0;
        set_req(0, 32'h60, 1'b0, 32'h0, 4'h0);
        ready = 1'b0;
        tick();
        for (int c = 0; c < 40 && !got; c++) begin
            tick();
            if (done !== '0) got = 1'b1;
            else if (enable === 1'b1) n_access++;
        end
        n_vec++; if (!got || n_access != TO) begin n_err++;
            $display("FAIL to_len got %0d access cycles (done seen=%0d) exp %0d", n_access, got, TO); end
        n_vec++; if (done !== NR'(1) || resp_err !== 1'b1 || resp_rdata !== '0 || sel !== 1'b0) begin n_err++;
            $display("FAIL to_done got done=%b err=%b rdata=%h sel=%b exp 001 1 0 0", done, resp_err, resp_rdata, sel); end
        drop_req(0);
        set_req(1, 32'h80, 1'b1, 32'h0000_55AA, 4'hF);
        ready = 1'b1;
        repeat (3) tick();
        n_vec++; if (done !== NR'(2) || resp_err !== 1'b0) begin n_err++;
            $display("FAIL to_next got done=%b err=%b exp 010 0", done, resp_err); end
        req = '0; ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        set_req(0, 32'h70, 1'b1, 32'h7, 4'h1);
        ready = 1'b1;
        repeat (3) tick();
        drop_req(0);
        set_req(1, 32'h90, 1'b0, 32'h0, 4'h0);
        ready = 1'b0;
        repeat (2) tick();
        n_vec++; if (enable !== 1'b1 || gnt !== NR'(2)) begin n_err++;
            $display("FAIL rst_pre got en=%b gnt=%b exp 1 010", enable, gnt); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (sel !== 1'b0 || enable !== 1'b0 || gnt !== '0 || done !== '0) begin n_err++;
            $display("FAIL rst_async got sel=%b en=%b gnt=%b done=%b exp 0", sel, enable, gnt, done); end
        #1 rst_n = 1'b1;
        req = req | NR'(1);
        tick();
        n_vec++; if (gnt !== NR'(1) || done !== '0) begin n_err++;
            $display("FAIL rst_ptr got gnt=%b done=%b exp 001 000", gnt, done); end
        ready = 1'b1;
        repeat (2) tick();
        n_vec++; if (done !== NR'(1)) begin n_err++;
            $display("FAIL rst_resume got done=%b exp 001", done); end
        req = '0; ready = 1'b0;
        tick();
    endtask

    // Transaction-level reference: bus owner, cycles since grant, rotating priority.
    int              m_owner;
    int              m_age;
    int              m_ptr;
    logic            m_write;
    logic [NR-1:0]   e_gnt, e_done;
    logic            e_sel, e_en, e_err;
    logic [DW-1:0]   e_rdata, e_wdata;
    logic [AW-1:0]   e_addr;
    logic [SW-1:0]   e_strobe;
    bit              stall;

    task automatic model_edge();
        logic [NR-1:0] elig;
        int            w;
        elig = req & ~e_done;
        e_done = '0; e_err = 1'b0; e_rdata = '0;
        if (m_owner < 0) begin
            if (elig != '0) begin
                w = -1;
                for (int k = 0; k < NR; k++)
                    if (w < 0 && ((elig >> ((m_ptr + k) % NR)) & NR'(1)) != '0) w = (m_ptr + k) % NR;
                m_owner  = w;
                m_age    = 1;
                e_sel    = 1'b1;
                e_en     = 1'b0;
                e_gnt    = NR'(1) << w;
                e_addr   = req_addr[w*AW +: AW];
                e_wdata  = req_wdata[w*DW +: DW];
                e_strobe = req_strobe[w*SW +: SW];
                m_write  = ((req_write >> w) & NR'(1)) != '0;
            end
        end else if (m_age == 1) begin
            m_age = 2;
            e_en  = 1'b1;
        end else if (ready || (m_age - 1) == TO) begin
            e_done  = NR'(1) << m_owner;
            e_err   = ready ? slverr : 1'b1;
            e_rdata = (ready && !slverr && !m_write) ? rdata : '0;
            m_ptr   = (m_owner + 1) % NR;
            m_owner = -1;
            e_sel   = 1'b0;
            e_en    = 1'b0;
            e_gnt   = '0;
        end else begin
            m_age++;
        end
    endtask

    task automatic test_random();
        do_reset();
        m_owner = -1; m_age = 0; m_ptr = 0; m_write = 1'b0;
        e_gnt = '0; e_done = '0; e_sel = 1'b0; e_en = 1'b0; e_err = 1'b0; e_rdata = '0;
        e_addr = '0; e_wdata = '0; e_strobe = '0; stall = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (((e_done >> i) & NR'(1)) != '0) drop_req(i);
                else if (((req >> i) & NR'(1)) == '0 && $urandom_range(0, 2) == 0)
                    set_req(i, $urandom, 1'($urandom_range(0, 1)), $urandom, SW'($urandom));
            end
            if (m_owner < 0) stall = ($urandom_range(0, 11) == 0);
            ready  = stall ? 1'b0 : ($urandom_range(0, 2) != 0);
            slverr = ($urandom_range(0, 5) == 0);
            rdata  = $urandom;
            model_edge();
            tick();
            n_vec++; if (sel !== e_sel || enable !== e_en) begin n_err++;
                $display("FAIL rand_phase cyc=%0d got sel=%b en=%b exp sel=%b en=%b", c, sel, enable, e_sel, e_en); end
            n_vec++; if (gnt !== e_gnt || done !== e_done) begin n_err++;
                $display("FAIL rand_gnt cyc=%0d got gnt=%b done=%b exp gnt=%b done=%b", c, gnt, done, e_gnt, e_done); end
            n_vec++; if (resp_err !== e_err || resp_rdata !== e_rdata) begin n_err++;
                $display("FAIL rand_resp cyc=%0d got err=%b rdata=%h exp err=%b rdata=%h", c, resp_err, resp_rdata, e_err, e_rdata); end
            if (e_sel) begin
                n_vec++; if (addr !== e_addr || write !== m_write || wdata !== e_wdata || strobe !== e_strobe) begin n_err++;
                    $display("FAIL rand_bus cyc=%0d got addr=%h wr=%b wdata=%h strb=%h exp addr=%h wr=%b wdata=%h strb=%h",
                             c, addr, write, wdata, strobe, e_addr, m_write, e_wdata, e_strobe); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_wait_states();
        test_slave_error();
        test_timeout();
        test_reset_mid_access();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
